// File: rtl/cbus_axi_bridge.sv
// Cache-bus to AXI4 master bridge: one transaction at a time, single-beat
// uncached accesses and INCR bursts for line refill/writeback.
package cbus_axi_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;      // beats - 1
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_axi_bridge
  import cbus_axi_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  cbus_req_t       creq,
  output cbus_resp_t      cresp,
  // read address channel
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [ID_W-1:0] arid,
  output logic            arvalid,
  input  logic            arready,
  // read data channel
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // write address channel
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [ID_W-1:0] awid,
  output logic            awvalid,
  input  logic            awready,
  // write data channel
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // write response channel
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  len_q;
  logic [3:0]  cnt_q;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        last_beat;

  // Response codes are not forwarded to the cache; the bus has no error path.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

  // Request fields are frozen at acceptance, so both address channels can
  // simply present the latched copy at all times.
  assign araddr  = addr_q;
  assign arlen   = {4'b0, len_q};
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign arid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = {4'b0, len_q};
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awid    = AXI_ID;
  assign wdata   = creq.data;
  assign wstrb   = creq.strobe;

  assign last_beat = (cnt_q == len_q);

  // State register, request capture in IDLE and write beat counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && creq.valid) begin
        addr_q <= creq.addr;
        size_q <= creq.size;
        len_q  <= creq.len;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
    end
  end

  // Next-state and channel handshake decode; inactive strobes stay low.
  // NOTE: every output of this block gets a default first, otherwise any
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    cresp   = '0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (creq.valid) state_d = creq.is_write ? AW : AR;
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        // Read beats pass straight through to the cache with no added delay.
        rready      = 1'b1;
        cresp.ready = rvalid;
        cresp.last  = rvalid & rlast;
        cresp.data  = rdata;
        if (rvalid && rlast) state_d = IDLE;
      end
      AW: begin
        awvalid = 1'b1;
        if (awready) begin
          cnt_clr = 1'b1;
          state_d = W;
        end
      end
      W: begin
        wvalid = 1'b1;
        wlast  = last_beat;
        if (wready) begin
          if (last_beat) begin
            // Final beat is acknowledged to the cache only after B.
            state_d = B;
          end else begin
            cresp.ready = 1'b1;
            cnt_inc     = 1'b1;
          end
        end
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          cresp.ready = 1'b1;
          cresp.last  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed self-checking bench for cbus_axi_bridge. Inputs change 1 time
// unit after the rising edge; outputs are compared 2 units later.
module tb_cbus_axi_bridge;
  import cbus_axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  cbus_req_t   creq;
  cbus_resp_t  cresp;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  arid, awid, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int vectors     = 0;
  int miscompares = 0;

  // loop bookkeeping (static, assigned before use)
  bit v;
  int beat, b, hs, pulses, n_ready;
  bit stalled, done;

  cbus_axi_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset), .creq(creq), .cresp(cresp),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arid(arid), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] strb, input logic [31:0] data);
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'd2;
    creq.addr     = addr;
    creq.len      = len;
    creq.strobe   = strb;
    creq.data     = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    creq    = '0;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 2'b10;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b11;
    cyc();
    #2;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid",  wvalid,  0);
    check("rst_rready",  rready,  0);
    check("rst_bready",  bready,  0);
    check("rst_cresp",   {cresp.ready, cresp.last}, 0);
    check("rst_cdata",   cresp.data, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // ---- single read ----
    set_req(0, 32'h1fc0_0000, 4'd0, 4'hF, 32'h0);
    #2;
    check("rd1_idle_arvalid", arvalid, 0);
    check("rd1_idle_ready", cresp.ready, 0);
    cyc();
    arready = 1;
    #2;
    check("rd1_arvalid", arvalid, 1);
    check("rd1_araddr", araddr, 32'h1fc0_0000);
    check("rd1_arlen", arlen, 0);
    check("rd1_arsize", arsize, 2);
    check("rd1_arburst", arburst, 2'b01);
    check("rd1_arid", arid, 0);
    check("rd1_awvalid", awvalid, 0);
    cyc();
    arready = 0;
    #2;
    check("rd1_rready", rready, 1);
    check("rd1_arvalid_off", arvalid, 0);
    check("rd1_wait_ready", cresp.ready, 0);
    cyc();
    rvalid = 1; rlast = 1; rdata = 32'hdead_beef;
    creq.valid = 0;
    #2;
    check("rd1_ready", cresp.ready, 1);
    check("rd1_last", cresp.last, 1);
    check("rd1_data", cresp.data, 32'hdead_beef);
    cyc();
    rvalid = 0; rlast = 0;
    #2;
    check("rd1_idle_rready", rready, 0);
    check("rd1_idle_ready2", cresp.ready, 0);
    cyc();

    // ---- 16-beat read, rvalid on every other cycle ----
    set_req(0, 32'h8000_0040, 4'd15, 4'hF, 32'h0);
    cyc();
    arready = 1;
    #2;
    check("rd16_arlen", arlen, 15);
    check("rd16_arvalid", arvalid, 1);
    cyc();
    arready = 0;
    n_ready = 0;
    for (int i = 0; i < 31; i++) begin
      v     = (i % 2 == 0);
      beat  = i / 2;
      rvalid = v;
      rdata  = 32'hA000_0000 + beat;
      rlast  = v && (beat == 15);
      if (i == 30) creq.valid = 0;
      #2;
      if (cresp.ready) n_ready++;
      check("rd16_ready", cresp.ready, v);
      check("rd16_last", cresp.last, v && (beat == 15));
      if (v) check("rd16_data", cresp.data, 32'hA000_0000 + beat);
      cyc();
    end
    rvalid = 0; rlast = 0;
    #2;
    check("rd16_ready_count", n_ready, 16);
    check("rd16_idle_rready", rready, 0);
    cyc();

    // ---- single write, awready delayed 3 cycles ----
    set_req(1, 32'h1000_0010, 4'd0, 4'b0011, 32'h1234_5678);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #2;
      check("wr1_awvalid", awvalid, 1);
      check("wr1_wvalid_early", wvalid, 0);
      cyc();
    end
    awready = 1;
    #2;
    check("wr1_awlen", awlen, 0);
    check("wr1_awaddr", awaddr, 32'h1000_0010);
    check("wr1_awburst", awburst, 2'b01);
    cyc();
    awready = 0;
    wready  = 1;
    #2;
    check("wr1_wvalid", wvalid, 1);
    check("wr1_awvalid_off", awvalid, 0);
    check("wr1_wlast", wlast, 1);
    check("wr1_wstrb", wstrb, 4'b0011);
    check("wr1_wdata", wdata, 32'h1234_5678);
    check("wr1_w_ready", cresp.ready, 0);
    cyc();
    wready = 0;
    #2;
    check("wr1_bready", bready, 1);
    check("wr1_wvalid_off", wvalid, 0);
    check("wr1_b_wait_ready", cresp.ready, 0);
    cyc();
    bvalid = 1;
    creq.valid = 0;
    #2;
    check("wr1_ready", cresp.ready, 1);
    check("wr1_last", cresp.last, 1);
    cyc();
    bvalid = 0;
    #2;
    check("wr1_idle_bready", bready, 0);
    check("wr1_idle_ready", cresp.ready, 0);
    cyc();

    // ---- 16-beat writeback, wready low on beats 3 and 9 ----
    set_req(1, 32'h2000_0000, 4'd15, 4'hF, 32'hC000_0000);
    cyc();
    awready = 1;
    #2;
    check("wr16_awlen", awlen, 15);
    cyc();
    awready = 0;
    b = 0; hs = 0; pulses = 0; stalled = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      creq.data   = 32'hC000_0000 + b;
      creq.strobe = 4'hF;
      if ((b == 2 || b == 8) && !stalled) begin
        wready  = 0;
        stalled = 1;
      end else begin
        wready = 1;
      end
      #2;
      check("wr16_wvalid", wvalid, 1);
      check("wr16_wdata", wdata, 32'hC000_0000 + b);
      check("wr16_wlast", wlast, b == 15);
      check("wr16_ready", cresp.ready, wready && (b != 15));
      check("wr16_last", cresp.last, 0);
      if (cresp.ready) pulses++;
      if (wvalid && wready) hs++;
      cyc();
      if (wready) begin
        if (b == 15) done = 1;
        else begin
          b++;
          stalled = 0;
        end
      end
    end
    wready = 0;
    #2;
    check("wr16_handshakes", hs, 16);
    check("wr16_pulses", pulses, 15);
    check("wr16_bready", bready, 1);
    check("wr16_b_wait_ready", cresp.ready, 0);
    cyc();
    bvalid = 1;
    creq.valid = 0;
    #2;
    check("wr16_b_ready", cresp.ready, 1);
    check("wr16_b_last", cresp.last, 1);
    cyc();
    bvalid = 0;
    cyc();

    // ---- read immediately followed by write ----
    set_req(0, 32'h3000_0000, 4'd0, 4'hF, 32'h0);
    cyc();
    arready = 1;
    cyc();
    arready = 0;
    rvalid = 1; rlast = 1; rdata = 32'h0000_0055;
    set_req(1, 32'h3000_0100, 4'd0, 4'hF, 32'hCAFE_0001);
    #2;
    check("rw_rd_last", cresp.last, 1);
    check("rw_rd_data", cresp.data, 32'h0000_0055);
    cyc();
    rvalid = 0; rlast = 0;
    #2;
    check("rw_gap_arvalid", arvalid, 0);
    check("rw_gap_awvalid", awvalid, 0);
    cyc();
    awready = 1;
    #2;
    check("rw_awvalid", awvalid, 1);
    check("rw_awaddr", awaddr, 32'h3000_0100);
    check("rw_no_ar", arvalid, 0);
    cyc();
    awready = 0;
    wready  = 1;
    #2;
    check("rw_wdata", wdata, 32'hCAFE_0001);
    cyc();
    wready = 0;
    bvalid = 1;
    creq.valid = 0;
    #2;
    check("rw_b_last", cresp.last, 1);
    cyc();
    bvalid = 0;
    cyc();

    // ---- reset asserted during beat 5 of a 16-beat read ----
    set_req(0, 32'h4000_0000, 4'd15, 4'hF, 32'h0);
    cyc();
    arready = 1;
    cyc();
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rlast = 0; rdata = 32'hB000_0000 + i;
      #2;
      check("rst_rd_ready", cresp.ready, 1);
      cyc();
    end
    rvalid = 1; rdata = 32'hB000_0004;
    #2;
    check("rst_beat5_ready", cresp.ready, 1);
    reset = 1;
    #1;
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_rready", rready, 0);
    check("rst_mid_cresp", {cresp.ready, cresp.last}, 0);
    check("rst_mid_cdata", cresp.data, 0);
    creq.valid = 0;
    rvalid = 0;
    cyc();
    reset = 0;
    #2;
    check("rst_rel_rready", rready, 0);
    cyc();
    set_req(0, 32'h5000_0000, 4'd3, 4'hF, 32'h0);
    cyc();
    arready = 1;
    #2;
    check("rst_new_arvalid", arvalid, 1);
    check("rst_new_arlen", arlen, 3);
    check("rst_new_araddr", araddr, 32'h5000_0000);
    cyc();
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rlast = (i == 3); rdata = 32'hD000_0000 + i;
      if (i == 3) creq.valid = 0;
      #2;
      check("rst_new_data", cresp.data, 32'hD000_0000 + i);
      check("rst_new_last", cresp.last, i == 3);
      cyc();
    end
    rvalid = 0; rlast = 0;
    #2;
    check("rst_new_idle", rready, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cbus_axi_bridge.md
Name: cbus_axi_bridge

Overview:
- Converts the single cache bus request/response stream produced after I/D arbitration (cbus_req_t / cbus_resp_t) into an AXI4 master interface toward the memory system.
- Sits directly downstream of the cache manager's bus arbiter output (creq/cresp).
- Handles one transaction at a time: single-beat uncached accesses and INCR bursts for cache line refill and writeback.

Parameters:
- AXI_ID, 4'd0, constant ID driven on arid/awid; rid/bid are ignored.
- ID_W, 4, width of arid/awid.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- creq  in  cbus_req_t  fields: valid, is_write, size[2:0], addr[31:0], strobe[3:0], data[31:0], len[3:0] (beats-1)
- cresp  out  cbus_resp_t  fields: ready, last, data[31:0]
- araddr/arlen/arsize/arburst/arid/arvalid  out  32/8/3/2/ID_W/1  AXI read address channel
- arready  in  1
- rdata/rresp/rlast/rvalid  in  32/2/1/1;  rready  out  1
- awaddr/awlen/awsize/awburst/awid/awvalid  out  32/8/3/2/ID_W/1  AXI write address channel
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1;  wready  in  1
- bresp/bvalid  in  2/1;  bready  out  1

Behaviour:
- States: IDLE, AR, R, AW, W, B. Reset (asynchronous) forces IDLE, beat counter 0, all AXI valid/ready outputs 0, cresp = 0.
- IDLE: if creq.valid, latch addr, size, len, is_write; next is AW if is_write, else AR. cresp.ready = 0. There is no same-cycle AXI issue; 1-cycle latency from creq.valid to arvalid/awvalid.
- AR: arvalid=1, araddr=latched addr, arlen={4'b0,len}, arsize=size, arburst=2'b01 (INCR), arid=AXI_ID. Hold until arready, then go to R.
- R: rready=1. cresp.ready = rvalid; cresp.data = rdata; cresp.last = rvalid & rlast. This is a combinational pass-through with no added latency. On rvalid & rlast go to IDLE. rresp is ignored.
- AW: awvalid=1 with the same field encoding as AR. On awready, clear beat counter and go to W. W is issued only after the AW handshake (no concurrent AW/W).
- W: wvalid=1, wdata=creq.data, wstrb=creq.strobe, wlast=(cnt==len).
  - On wvalid & wready with wlast=0: cresp.ready=1 for that cycle and cnt++. The master advances its data on this pulse.
  - On the wlast handshake: cresp.ready=0; go to B.
- B: bready=1. On bvalid, cresp.ready=1 and cresp.last=1 for one cycle, then go to IDLE. bresp is ignored.
- Write completion is reported only after B, so the final write beat's ready coincides with last.
- Beat counter is 4 bits and counts 0..len. len=0 gives a single beat with wlast asserted on the first beat. Max burst is 16 beats; the counter never wraps within a transaction.
- creq fields other than data/strobe are sampled only in IDLE. Changes to addr/len/is_write mid-transaction are ignored.
- If creq.valid deasserts mid-transaction (protocol violation), the bridge still completes the AXI transaction and returns to IDLE. No AXI channel is left hanging.
- Back-to-back: after returning to IDLE, a still-asserted creq.valid (next arbiter grant) starts a new transaction on the following cycle. There is a minimum 1 idle cycle between transactions.
- Outputs not active in the current state are driven 0 (valid/ready/last). Address/data buses may hold latched values.
- Reset asserted mid-burst: immediate return to IDLE with all outputs 0. The slave is expected to be reset concurrently.

Test Plan:
- Single read: creq{valid=1,is_write=0,addr=0x1fc0_0000,size=2,len=0}; arready=1 next cycle; rdata=0xdead_beef, rlast=1 after 2 cycles -> arlen=0, arburst=01; cresp.ready=last=1 with data 0xdead_beef in exactly that cycle; then IDLE.
- 16-beat read with rvalid gaps every other cycle -> arlen=15; cresp.ready asserted exactly 16 times, only on rvalid cycles; last only on beat 16; data order matches rdata.
- Single write: len=0, strobe=4'b0011, data=0x1234_5678; awready delayed 3 cycles -> wvalid rises only after the AW handshake; wlast=1, wstrb=0011; cresp.ready=last=1 only in the bvalid cycle.
- 16-beat writeback with wready low on beats 3 and 9 -> exactly 16 W handshakes; wlast only on beat 16; cresp.ready pulses on the 15 non-final beats plus once with last at B; wdata follows creq.data each beat.
- Read immediately followed by write (creq held valid with new fields after the read's last) -> one idle cycle, then awvalid with the new addr; no overlap of AR and AW.
- Reset asserted during beat 5 of a 16-beat read -> same-cycle (async) arvalid=rready=0, cresp=0. After release, a new read starts cleanly with arlen from the new request.
